// File: rtl/branch_predictor_dyn_pkg.sv
// Shared types and helpers for the dynamic branch predictor: counter encoding,
// BTB entry layout and B-type immediate decode.
package branch_pred_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // Widest tag any legal ENTRIES (>= 2) can need; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 29;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/branch_predictor_dyn_if.sv
// Fetch-side prediction and execute-side training signals of the branch predictor.
interface branch_predictor_dyn_if;
    logic [31:0] iPCF;
    logic [31:0] iInstructionF;
    logic        oTakeBranch;
    logic [31:0] oBranchTarget;
    logic        iUpdateE;
    logic [31:0] iPCE;
    logic        iTakenE;
    logic [31:0] iTargetE;

    modport master (
        output iPCF, iInstructionF, iUpdateE, iPCE, iTakenE, iTargetE,
        input  oTakeBranch, oBranchTarget
    );

    modport slave (
        input  iPCF, iInstructionF, iUpdateE, iPCE, iTakenE, iTargetE,
        output oTakeBranch, oBranchTarget
    );
endinterface

// File: rtl/branch_predictor_dyn_sat_counter.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module bp_sat_counter
    import branch_pred_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t nextCtr
);

    // Step toward strong-taken or strong-not-taken, holding at either end.
    always_comb begin
        nextCtr = ctr;
        case (ctr)
            SNT:     nextCtr = taken ? WNT : SNT;
            WNT:     nextCtr = taken ? WT  : SNT;
            WT:      nextCtr = taken ? ST  : WNT;
            ST:      nextCtr = taken ? ST  : WT;
            default: nextCtr = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predictor_dyn.sv
// Direct-mapped BTB with 2-bit counters; static backward-taken prediction on a miss.
module branch_predictor_dyn
    import branch_pred_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input logic                   clk,
    input logic                   rst,
    branch_predictor_dyn_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    btb_entry_t           btb_r [ENTRIES];
    logic [IDX_W-1:0]     fIdx_s;
    logic [IDX_W-1:0]     eIdx_s;
    logic [TAG_MAX_W-1:0] fTag_s;
    logic [TAG_MAX_W-1:0] eTag_s;
    btb_entry_t           fEnt_s;
    btb_entry_t           eEnt_s;
    logic                 fHit_s;
    logic                 eHit_s;
    ctr_t                 eNextCtr_s;
    logic                 predTake_s;
    logic [31:0]          predTarget_s;
    logic                 unusedBits_s;

    assign fIdx_s = bp.iPCF[IDX_W+1:2];
    assign eIdx_s = bp.iPCE[IDX_W+1:2];
    assign fTag_s = TAG_MAX_W'(bp.iPCF[31:IDX_W+2]);
    assign eTag_s = TAG_MAX_W'(bp.iPCE[31:IDX_W+2]);

    assign fEnt_s = btb_r[fIdx_s];
    assign eEnt_s = btb_r[eIdx_s];
    assign fHit_s = fEnt_s.valid && (fEnt_s.tag == fTag_s);
    assign eHit_s = eEnt_s.valid && (eEnt_s.tag == eTag_s);

    assign unusedBits_s = ^{bp.iPCF[1:0], bp.iPCE[1:0], bp.iInstructionF[24:12]};

    bp_sat_counter u_sat_counter (
        .ctr     (eEnt_s.ctr),
        .taken   (bp.iTakenE),
        .nextCtr (eNextCtr_s)
    );

    // Same-cycle prediction from the current table; no bypass of a pending update.
    always_comb begin
        predTake_s   = 1'b0;
        predTarget_s = 32'd0;
        if (bp.iInstructionF[6:0] == OPCODE_BRANCH) begin
            if (fHit_s) begin
                predTake_s   = fEnt_s.ctr[1];
                predTarget_s = fEnt_s.ctr[1] ? fEnt_s.target : 32'd0;
            end else begin
                predTake_s   = bp.iInstructionF[31];
                predTarget_s = bp.iInstructionF[31]
                             ? (bp.iPCF + b_imm(bp.iInstructionF)) : 32'd0;
            end
        end else begin
            predTake_s   = 1'b0;
            predTarget_s = 32'd0;
        end
    end

    assign bp.oTakeBranch   = predTake_s;
    assign bp.oBranchTarget = predTarget_s;

    // Table training; reset clears valid/ctr only and always beats a concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_r[i].valid <= 1'b0;
                btb_r[i].ctr   <= CTR_RESET;
            end
        end else if (bp.iUpdateE) begin
            if (eHit_s) begin
                btb_r[eIdx_s].ctr <= eNextCtr_s;
                if (bp.iTakenE) begin
                    btb_r[eIdx_s].target <= bp.iTargetE;
                end
            end else if (bp.iTakenE) begin
                btb_r[eIdx_s] <= '{valid: 1'b1, tag: eTag_s,
                                   target: bp.iTargetE, ctr: CTR_ALLOC};
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_dyn.sv
// Directed vector bench for branch_predictor_dyn (ENTRIES=16).
module tb_branch_predictor_dyn;

    localparam logic [31:0] BWD = 32'hFE000EE3; // beq, imm -4
    localparam logic [31:0] FWD = 32'h00000463; // beq, imm +8
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic        rstV;
        logic        upd;
        logic [31:0] pcE;
        logic        takenE;
        logic [31:0] tgtE;
        logic [31:0] pcF;
        logic [31:0] inst;
        logic        chk;
        logic        expTake;
        logic [31:0] expTgt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   totalCnt = 0;
    int   passCnt  = 0;
    vec_t vecs[$];

    branch_predictor_dyn_if bpIf ();

    branch_predictor_dyn #(.ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bpIf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic u, input logic [31:0] pe,
                                input logic tk, input logic [31:0] te, input logic [31:0] pf,
                                input logic [31:0] in, input logic c, input logic et,
                                input logic [31:0] eg);
        vec_t v;
        v.rstV = r; v.upd = u; v.pcE = pe; v.takenE = tk; v.tgtE = te;
        v.pcF = pf; v.inst = in; v.chk = c; v.expTake = et; v.expTgt = eg;
        return v;
    endfunction

    // Drive one cycle's inputs, compare at the falling edge, then let the clock edge commit.
    task automatic step(input vec_t v, input int id);
        rst                = v.rstV;
        bpIf.iUpdateE      = v.upd;
        bpIf.iPCE          = v.pcE;
        bpIf.iTakenE       = v.takenE;
        bpIf.iTargetE      = v.tgtE;
        bpIf.iPCF          = v.pcF;
        bpIf.iInstructionF = v.inst;
        @(negedge clk);
        if (v.chk) begin
            totalCnt++;
            if (bpIf.oTakeBranch === v.expTake && bpIf.oBranchTarget === v.expTgt) begin
                passCnt++;
            end else begin
                $display("FAIL vec%0d pc=%h: take/target got %0b/%h want %0b/%h",
                         id, v.pcF, bpIf.oTakeBranch, bpIf.oBranchTarget,
                         v.expTake, v.expTgt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset and static prediction
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h100, NOP, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h100, BWD, 1, 1, 32'h0FC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h100, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h100, NOP, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, BWD, 1, 1, 32'hFFFFFFFC));
        // allocate 0x200, then hysteresis both ways
        vecs.push_back(mk(0, 1, 32'h200, 1, 32'h240, 32'h200, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h200, FWD, 1, 1, 32'h240));
        vecs.push_back(mk(0, 1, 32'h200, 1, 32'h240, 32'h200, FWD, 1, 1, 32'h240));
        vecs.push_back(mk(0, 1, 32'h200, 1, 32'h240, 32'h200, FWD, 1, 1, 32'h240));
        vecs.push_back(mk(0, 1, 32'h200, 1, 32'h240, 32'h200, FWD, 1, 1, 32'h240));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 32'h200, FWD, 1, 1, 32'h240));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h200, FWD, 1, 1, 32'h240));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 32'h200, FWD, 1, 1, 32'h240));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h200, BWD, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 32'h200, BWD, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 1, 32'h280, 32'h200, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h200, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 1, 32'h280, 32'h200, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h200, FWD, 1, 1, 32'h280));
        // alias: 0x240 evicts 0x200; a not-taken miss changes nothing
        vecs.push_back(mk(0, 1, 32'h240, 1, 32'h400, 32'h240, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h200, BWD, 1, 1, 32'h1FC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h240, FWD, 1, 1, 32'h400));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 32'h240, FWD, 1, 1, 32'h400));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h200, FWD, 1, 0, 0));
        // same-cycle update and fetch: no bypass
        vecs.push_back(mk(0, 1, 32'h300, 1, 32'h500, 32'h300, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h300, FWD, 1, 1, 32'h500));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h240, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h300, NOP, 1, 0, 0));
        // reset beats update and clears history
        vecs.push_back(mk(1, 1, 32'h344, 1, 32'h600, 32'h300, NOP, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h344, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h300, FWD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h300, BWD, 1, 1, 32'h2FC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h344, NOP, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Nonzero index with PC[1:0] set on the update, then a same-index different-tag miss.
        step(mk(0, 1, 32'h1007, 1, 32'hABC, 32'h1004, FWD, 1, 0, 0), 100);
        step(mk(0, 0, 0, 0, 0, 32'h1004, FWD, 1, 1, 32'hABC), 101);
        step(mk(0, 0, 0, 0, 0, 32'h1006, FWD, 1, 1, 32'hABC), 102);
        step(mk(0, 0, 0, 0, 0, 32'h1044, FWD, 1, 0, 0), 103);
        step(mk(0, 1, 32'h1004, 0, 0, 32'h1004, FWD, 1, 1, 32'hABC), 104);
        step(mk(0, 0, 0, 0, 0, 32'h1004, FWD, 1, 0, 0), 105);
        step(mk(0, 0, 0, 0, 0, 32'h1004, BWD, 1, 0, 0), 106);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
